// File: rtl/sar_search.sv
// Successive-approximation search: recovers an unknown value by probing an external
// magnitude comparator one bit at a time, MSB first. Optional SAR_EARLY_EXIT_EN ends on an exact match.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] trial,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    input  logic             cmp_lt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cmp_err
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        TRY
    } state_t;

    state_t           state;
    logic [IW-1:0]    bit_idx;

    logic [WIDTH-1:0] cur_mask;
    logic [WIDTH-1:0] decided;
    logic [WIDTH-1:0] next_trial;
    logic [WIDTH-1:0] final_val;
    logic             one_hot;
    logic             keep;
    logic             finish;

    // A malformed comparator code is treated as "a < trial", so the probed bit is dropped.
    always_comb begin
        cur_mask   = WIDTH'(1) << bit_idx;
        one_hot    = (cmp_gt ^ cmp_eq ^ cmp_lt) & ~(cmp_gt & cmp_eq & cmp_lt);
        keep       = one_hot & (cmp_gt | cmp_eq);
        decided    = keep ? trial : (trial & ~cur_mask);
        next_trial = decided | (cur_mask >> 1);
        finish     = (bit_idx == '0);
        final_val  = decided;
`ifdef SAR_EARLY_EXIT_EN
        if (one_hot && cmp_eq) begin
            finish    = 1'b1;
            final_val = trial;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            trial   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cmp_err <= 1'b0;
            bit_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= TRY;
                        trial   <= {1'b1, {(WIDTH-1){1'b0}}};
                        bit_idx <= IW'(WIDTH - 1);
                        busy    <= 1'b1;
                        cmp_err <= 1'b0;
                    end
                end
                TRY: begin
                    if (!one_hot) begin
                        cmp_err <= 1'b1;
                    end
                    if (finish) begin
                        state   <= IDLE;
                        result  <= final_val;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        trial   <= '0;
                        bit_idx <= '0;
                    end else begin
                        trial   <= next_trial;
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: a behavioural comparator plus a value-level
// reference model (recovered value, probe sequence, latency). Honours SAR_EARLY_EXIT_EN.
module tb_sar_search;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] trial;
    logic         cmp_gt;
    logic         cmp_eq;
    logic         cmp_lt;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cmp_err;

    logic [W-1:0] a_val;
    logic         inject;

    int tests;
    int failures;

    sar_search #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .trial   (trial),
        .cmp_gt  (cmp_gt),
        .cmp_eq  (cmp_eq),
        .cmp_lt  (cmp_lt),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cmp_err (cmp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model; inject forces the illegal gt+lt code.
    assign cmp_gt = inject ? 1'b1 : (a_val > trial);
    assign cmp_eq = inject ? 1'b0 : (a_val == trial);
    assign cmp_lt = inject ? 1'b1 : (a_val < trial);

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Probe k (1-based) keeps a's bits above the probed bit and sets the probed bit.
    function automatic int refTrial(input int a, input int k);
        int b;
        b = W - k;
        return ((a >> (b + 1)) << (b + 1)) | (1 << b);
    endfunction

    function automatic int refLatency(input int a);
`ifdef SAR_EARLY_EXIT_EN
        int tz;
        if (a == 0) return W;
        tz = 0;
        while (((a >> tz) & 1) == 0) tz++;
        return W - tz;
`else
        return W;
`endif
    endfunction

    // Starts a search at the current negedge and follows it to done.
    task automatic applyStimulus(input int a, input int exp_res, input int exp_err,
                                 input int err_edge, input bit repulse);
        int edges;
        int exp_lat;
        exp_lat = (err_edge == 0) ? refLatency(a) : W;
        a_val = W'(a);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        edges = 0;
        while (!done && edges < W + 4) begin
            if (err_edge == 0 && edges < W)
                checkOutput($sformatf("trial_a%0d_k%0d", a, edges + 1), int'(trial), refTrial(a, edges + 1));
            inject = (edges + 1 == err_edge);
            start  = repulse && (edges == 1);
            @(negedge clk);
            edges++;
            inject = 1'b0;
            start  = 1'b0;
        end
        checkOutput($sformatf("latency_a%0d", a), edges, exp_lat);
        checkOutput($sformatf("result_a%0d", a), int'(result), exp_res);
        checkOutput("cmp_err", int'(cmp_err), exp_err);
        checkOutput("busy_at_done", int'(busy), 0);
        checkOutput("trial_at_done", int'(trial), 0);
    endtask

    task automatic idleCheck();
        @(negedge clk);
        checkOutput("done_pulse_width", int'(done), 0);
        checkOutput("stays_idle", int'(busy), 0);
    endtask

    initial begin
        int a;
        bit errv;
        tests    = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        inject   = 1'b0;
        a_val    = '0;
        #12;
        checkOutput("rst_trial", int'(trial), 0);
        checkOutput("rst_result", int'(result), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_cmp_err", int'(cmp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: a=1011, then 0 and 15 back to back.
        applyStimulus(11, 11, 0, 0, 1'b0);
        idleCheck();
        applyStimulus(0, 0, 0, 0, 1'b0);
        applyStimulus(15, 15, 0, 0, 1'b0);
        idleCheck();
        applyStimulus(8, 8, 0, 0, 1'b0);
        idleCheck();

        // Illegal code on the second TRY edge with a=1111.
        applyStimulus(15, 11, 1, 2, 1'b0);
        idleCheck();
        applyStimulus(5, 5, 0, 0, 1'b0);
        idleCheck();

        // Garbage on the comparator while idle must not set cmp_err.
        inject = 1'b1;
        repeat (3) @(negedge clk);
        inject = 1'b0;
        checkOutput("idle_cmp_ignored", int'(cmp_err), 0);

        // start re-pulsed mid-search.
        applyStimulus(6, 6, 0, 0, 1'b1);
        idleCheck();
        applyStimulus(13, 13, 0, 0, 1'b1);
        idleCheck();

        // Reset mid-search after two TRY edges.
        a_val = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_trial", int'(trial), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_result", int'(result), 0);
        checkOutput("abort_cmp_err", int'(cmp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_reset_no_done", int'(done), 0);
            checkOutput("post_reset_idle", int'(busy), 0);
        end
        applyStimulus(9, 9, 0, 0, 1'b0);
        idleCheck();

        // Randomized searches, sometimes chained on the done cycle, sometimes with a fault.
        for (int i = 0; i < 24; i++) begin
            a    = int'($urandom_range(0, (1 << W) - 1));
            errv = ($urandom_range(0, 4) == 0);
            if (errv && a == 15)
                applyStimulus(15, 11, 1, 2, 1'b0);
            else
                applyStimulus(a, a, 0, 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1)
                idleCheck();
        end
        idleCheck();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
